// File: rtl/lif_neuron_param.sv
`default_nettype none
// lif_neuron_param: parametrised leaky integrate-and-fire neuron with signed weights,
// saturating membrane, zero/subtract post-fire reset, refractory window and spike counter.
module lif_neuron_param #(
  parameter int M  = 8,
  parameter int W  = 4,
  parameter int VW = 8,
  parameter int DW = 4,
  parameter int RW = 5,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [M-1:0]    input_spikes,
  input  logic [M*W-1:0]  weights,
  input  logic [VW-1:0]   threshold,
  input  logic [DW-1:0]   decay,
  input  logic [RW-1:0]   refractory_period,
  input  logic            reset_mode,
  input  logic            clear_count,
  output logic [VW-1:0]   membrane_potential_out,
  output logic            spike_out,
  output logic            refractory_active,
  output logic [CW-1:0]   spike_count
);

  localparam int LM = $clog2(M);
  localparam int IW = W + LM + 1;
  localparam int TW = VW + W + LM + 2;
  localparam logic [CW-1:0] CMAX = '1;

  logic [VW-1:0]        v_q, v_d;
  logic [RW-1:0]        refr_q, refr_d;
  logic                 spk_q, spk_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [W-1:0]  w_ch [M];
  logic signed [IW-1:0] cur;
  logic signed [TW-1:0] tmp, sub, thr_ext;
  logic                 fire;

  for (genvar i = 0; i < M; i++) begin : g_w
    assign w_ch[i] = weights[i*W +: W];
  end

  always_comb begin
    cur = '0;
    for (int i = 0; i < M; i++) begin
      if (input_spikes[i]) cur = cur + IW'(w_ch[i]);
    end
  end

  // TW leaves headroom above VW, so the sign bit and the bits above VW decide the clamp
  function automatic logic [VW-1:0] clamp(input logic signed [TW-1:0] x);
    if (x[TW-1])              return '0;
    else if (|x[TW-2:VW])     return '1;
    else                      return x[VW-1:0];
  endfunction

  assign thr_ext = signed'(TW'(threshold));
  assign tmp     = signed'(TW'(v_q)) + TW'(cur) - signed'(TW'(decay));
  assign sub     = tmp - thr_ext;
  assign fire    = enable && (refr_q == '0) && (tmp >= thr_ext);

  always_comb begin
    v_d    = v_q;
    refr_d = refr_q;
    spk_d  = 1'b0;
    cnt_d  = cnt_q;
    if (enable) begin
      if (refr_q != '0) begin
        refr_d = refr_q - RW'(1);
      end else if (fire) begin
        spk_d  = 1'b1;
        refr_d = refractory_period;
        v_d    = reset_mode ? clamp(sub) : '0;
      end else begin
        v_d = clamp(tmp);
      end
    end
    if (clear_count)                 cnt_d = '0;
    else if (fire && cnt_q != CMAX)  cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q    <= '0;
      refr_q <= '0;
      spk_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      v_q    <= v_d;
      refr_q <= refr_d;
      spk_q  <= spk_d;
      cnt_q  <= cnt_d;
    end
  end

  assign membrane_potential_out = v_q;
  assign spike_out              = spk_q;
  assign refractory_active      = (refr_q != '0);
  assign spike_count            = cnt_q;

endmodule
`default_nettype wire
